// File: rtl/mx_dot_accum_if.sv
// mx_dot_accum_if
//   Groups the beat input stream and the result output stream of
//   mx_dot_accum. The slave modport is the accumulator itself; the master
//   modport is the upstream producer / downstream consumer side.
//   Beat stream  : i_dp, i_exp_a, i_exp_b, i_last, i_valid -> o_ready
//   Result stream: o_valid, o_acc, o_exp, o_nan, o_sat    <- i_ready
interface mx_dot_accum_if #(
  parameter int DP_WIDTH  = 21,
  parameter int ACC_WIDTH = 32
);
  logic [DP_WIDTH-1:0]  i_dp;
  logic [7:0]           i_exp_a;
  logic [7:0]           i_exp_b;
  logic                 i_last;
  logic                 i_valid;
  logic                 o_ready;
  logic                 o_valid;
  logic                 i_ready;
  logic [ACC_WIDTH-1:0] o_acc;
  logic [8:0]           o_exp;
  logic                 o_nan;
  logic                 o_sat;

  modport slave (
    input  i_dp, i_exp_a, i_exp_b, i_last, i_valid, i_ready,
    output o_ready, o_valid, o_acc, o_exp, o_nan, o_sat
  );

  modport master (
    output i_dp, i_exp_a, i_exp_b, i_last, i_valid, i_ready,
    input  o_ready, o_valid, o_acc, o_exp, o_nan, o_sat
  );
endinterface

// File: rtl/mx_dot_accum.sv
// mx_dot_accum
//   Block-floating-point accumulator behind dot_int. Each accepted beat
//   carries a signed block dot product and the two E8M0 block scales; beats
//   are aligned to a running (acc, exp) pair and summed until i_last. One
//   result per group is then held on the output until consumed. The value
//   represented is o_acc * 2^(o_exp - 254).
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : mx_dot_accum_if.slave (beat stream in, result stream out)
module mx_dot_accum #(
  parameter int BIT_WIDTH = 8,
  parameter int K         = 32,
  parameter int DP_WIDTH  = 2 * BIT_WIDTH + $clog2(K),
  parameter int ACC_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mx_dot_accum_if.slave bus
);
  localparam int SH_W = $clog2(ACC_WIDTH);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t                      state_q, state_d;
  logic                        empty_q, empty_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [8:0]                  exp_q, exp_d;
  logic                        nan_q, nan_d;
  logic                        sat_q, sat_d;
  logic [ACC_WIDTH-1:0]        o_acc_q, o_acc_d;
  logic [8:0]                  o_exp_q, o_exp_d;
  logic                        o_nan_q, o_nan_d;
  logic                        o_sat_q, o_sat_d;

  // Beat datapath
  logic                        beat_ok;
  logic                        beat_nan;
  logic [8:0]                  e_sum;
  logic signed [ACC_WIDTH-1:0] d_ext;
  logic                        up;
  logic [8:0]                  diff;
  logic [SH_W-1:0]             sh;
  logic signed [ACC_WIDTH-1:0] big_op, small_op;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        ovf;
  logic signed [ACC_WIDTH-1:0] clamped;

  // Ready drops combinationally with rst so nothing is taken during reset.
  assign bus.o_ready = (state_q == S_ACC) && !rst;
  assign bus.o_valid = (state_q == S_OUT);
  assign bus.o_acc   = o_acc_q;
  assign bus.o_exp   = o_exp_q;
  assign bus.o_nan   = o_nan_q;
  assign bus.o_sat   = o_sat_q;

  assign beat_ok  = bus.i_valid && bus.o_ready;
  assign beat_nan = (bus.i_exp_a == 8'hFF) || (bus.i_exp_b == 8'hFF);
  assign e_sum    = {1'b0, bus.i_exp_a} + {1'b0, bus.i_exp_b};
  assign d_ext    = {{(ACC_WIDTH-DP_WIDTH){bus.i_dp[DP_WIDTH-1]}}, bus.i_dp};
  assign up       = e_sum > exp_q;
  assign diff     = up ? (e_sum - exp_q) : (exp_q - e_sum);
  // Shifting by acc_width-1 already collapses any value to 0 or -1.
  assign sh       = (diff > 9'(ACC_WIDTH-1)) ? SH_W'(ACC_WIDTH-1) : diff[SH_W-1:0];

  // The operand with the smaller exponent is shifted down to the larger one.
  assign big_op   = up ? (acc_q >>> sh) : acc_q;
  assign small_op = up ? d_ext : (d_ext >>> sh);
  assign sum      = {big_op[ACC_WIDTH-1], big_op} + {small_op[ACC_WIDTH-1], small_op};
  assign ovf      = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign clamped  = !ovf ? sum[ACC_WIDTH-1:0] :
                    sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                     {1'b0, {(ACC_WIDTH-1){1'b1}}};

  always_comb begin
    state_d = state_q;
    empty_d = empty_q;
    acc_d   = acc_q;
    exp_d   = exp_q;
    nan_d   = nan_q;
    sat_d   = sat_q;
    o_acc_d = o_acc_q;
    o_exp_d = o_exp_q;
    o_nan_d = o_nan_q;
    o_sat_d = o_sat_q;
    if (state_q == S_ACC) begin
      if (beat_ok) begin
        // A NaN-scaled beat only poisons the group; its data is ignored.
        if (beat_nan) begin
          nan_d = 1'b1;
        end else if (empty_q) begin
          acc_d   = d_ext;
          exp_d   = e_sum;
          empty_d = 1'b0;
        end else begin
          acc_d = clamped;
          exp_d = up ? e_sum : exp_q;
          if (ovf) sat_d = 1'b1;
        end
        if (bus.i_last) begin
          state_d = S_OUT;
          o_nan_d = nan_d;
          o_sat_d = sat_d;
          o_acc_d = nan_d ? '0 : acc_d;
          o_exp_d = nan_d ? '0 : exp_d;
        end
      end
    end else if (bus.i_ready) begin
      state_d = S_ACC;
      empty_d = 1'b1;
      nan_d   = 1'b0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      empty_q <= 1'b1;
      acc_q   <= '0;
      exp_q   <= '0;
      nan_q   <= 1'b0;
      sat_q   <= 1'b0;
      o_acc_q <= '0;
      o_exp_q <= '0;
      o_nan_q <= 1'b0;
      o_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      empty_q <= empty_d;
      acc_q   <= acc_d;
      exp_q   <= exp_d;
      nan_q   <= nan_d;
      sat_q   <= sat_d;
      o_acc_q <= o_acc_d;
      o_exp_q <= o_exp_d;
      o_nan_q <= o_nan_d;
      o_sat_q <= o_sat_d;
    end
  end
endmodule
